// File: rtl/rgb_input_conditioner.sv
// rgb_input_conditioner
// Synchronizes and debounces the two slide switches and four push buttons
// feeding the RGB decoder. Produces the clean decoder code
// {sw_db[1], sw_db[0], bit0} with a one-cycle change strobe, plus a
// one-cycle press pulse per button on each debounced rising edge.
//
// Optional build macro: RGB_BTN_TOGGLE_EN
//   undefined : code[0] follows the debounced level of btn[0]
//   defined   : code[0] is a toggle register flipped by each btn[0] press
module rgb_input_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 32'd1250000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] sw,
    input  logic [3:0] btn,
    output logic [2:0] code,
    output logic       code_valid,
    output logic [1:0] sw_db,
    output logic [3:0] btn_db,
    output logic [3:0] btn_press
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 32'd1);
    localparam int unsigned NBITS = 32'd6;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 32'd1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    // Bit map of the conditioned vector: [1:0] = sw, [5:2] = btn
    logic [NBITS-1:0] raw_s;
    logic [NBITS-1:0] sync1_r;
    logic [NBITS-1:0] sync2_r;
    logic [NBITS-1:0] db_r;
    logic [NBITS-1:0] db_next_s;
    logic [CNT_W-1:0] cnt_r      [NBITS];
    logic [CNT_W-1:0] cnt_next_s [NBITS];

    logic [3:0] press_next_s;
    logic       bit0_next_s;
    logic [2:0] code_next_s;
    logic [2:0] code_r;
    logic       code_valid_r;
    logic [3:0] btn_press_r;

`ifdef RGB_BTN_TOGGLE_EN
    logic       toggle_r;
    logic       toggle_next_s;
`endif

    assign raw_s = {btn, sw};

    // Per-bit debounce next state: count consecutive mismatch cycles, commit after DEBOUNCE_CYCLES
    always_comb begin
        for (int i = 0; i < NBITS; i++) begin
            db_next_s[i]  = db_r[i];
            cnt_next_s[i] = CNT_ZERO;
            if (sync2_r[i] == db_r[i]) begin
                // matching sample (stable or a bounce) restarts the count
                cnt_next_s[i] = CNT_ZERO;
            end else if (cnt_r[i] >= CNT_LAST) begin
                // >= rather than == so a corrupted counter can never run past the limit
                db_next_s[i]  = sync2_r[i];
                cnt_next_s[i] = CNT_ZERO;
            end else begin
                cnt_next_s[i] = cnt_r[i] + CNT_W'(1);
            end
        end
    end

    // Decoder code, press pulses and toggle computed from next-state debounced levels
    always_comb begin
        press_next_s = db_next_s[5:2] & ~db_r[5:2];
`ifdef RGB_BTN_TOGGLE_EN
        toggle_next_s = toggle_r ^ press_next_s[0];
        bit0_next_s   = toggle_next_s;
`else
        bit0_next_s   = db_next_s[2];
`endif
        code_next_s = {db_next_s[1], db_next_s[0], bit0_next_s};
    end

    // State and registered outputs; code, levels and pulses all update on the same edge
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r      <= {NBITS{1'b0}};
            sync2_r      <= {NBITS{1'b0}};
            db_r         <= {NBITS{1'b0}};
            code_r       <= 3'b000;
            code_valid_r <= 1'b0;
            btn_press_r  <= 4'b0000;
            for (int i = 0; i < NBITS; i++) begin
                cnt_r[i] <= CNT_ZERO;
            end
`ifdef RGB_BTN_TOGGLE_EN
            toggle_r     <= 1'b0;
`endif
        end else begin
            sync1_r      <= raw_s;
            sync2_r      <= sync1_r;
            db_r         <= db_next_s;
            code_r       <= code_next_s;
            code_valid_r <= (code_next_s != code_r);
            btn_press_r  <= press_next_s;
            for (int i = 0; i < NBITS; i++) begin
                cnt_r[i] <= cnt_next_s[i];
            end
`ifdef RGB_BTN_TOGGLE_EN
            toggle_r     <= toggle_next_s;
`endif
        end
    end

    assign code       = code_r;
    assign code_valid = code_valid_r;
    assign sw_db      = db_r[1:0];
    assign btn_db     = db_r[5:2];
    assign btn_press  = btn_press_r;

endmodule

// File: tb/tb_rgb_input_conditioner.sv
// Bench for rgb_input_conditioner with DEBOUNCE_CYCLES = 4.
// The reference model keeps a per-edge history of raw samples and decides a
// debounced flip when the last D synchronized samples all disagree with the
// current level; expected levels and pulse events are queued and a separate
// monitor pops and compares them against the DUT.
module tb_rgb_input_conditioner;

    localparam int D    = 4;
    localparam int NCYC = 8192;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] sw  = 2'b00;
    logic [3:0] btn = 4'b0000;
    logic [2:0] code;
    logic       code_valid;
    logic [1:0] sw_db;
    logic [3:0] btn_db;
    logic [3:0] btn_press;

    rgb_input_conditioner #(.DEBOUNCE_CYCLES(D)) dut (
        .clk        (clk),
        .rst        (rst),
        .sw         (sw),
        .btn        (btn),
        .code       (code),
        .code_valid (code_valid),
        .sw_db      (sw_db),
        .btn_db     (btn_db),
        .btn_press  (btn_press)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [2:0] code;
        logic [1:0] sw;
        logic [3:0] btn;
    } lvl_t;

    typedef struct {
        int         cyc;
        logic [3:0] press;
    } ev_t;

    lvl_t lvl_q[$];
    ev_t  code_q[$];
    ev_t  press_q[$];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    bit mon_en  = 1'b0;

    // reference model state
    logic [5:0] samp [0:NCYC-1];
    bit         rstv [0:NCYC-1];
    logic [5:0] db_m     = 6'd0;
    logic [2:0] code_m   = 3'd0;
    logic       tog_m    = 1'b0;
    int         last_rst = 0;

    // synchronized value the debouncer sees at edge idx (raw from two edges earlier)
    function automatic logic [5:0] used_at(input int idx);
        if (idx < 3) return 6'd0;
        if (rstv[idx-1]) return 6'd0;
        return samp[idx-2];
    endfunction

    task automatic model_edge(input int k, input logic r, input logic [5:0] raw);
        logic [5:0] nd;
        logic [3:0] pr;
        logic [2:0] nc;
        logic       mis;
        samp[k] = r ? 6'd0 : raw;
        rstv[k] = r;
        if (r) begin
            db_m     = 6'd0;
            code_m   = 3'd0;
            tog_m    = 1'b0;
            last_rst = k;
        end else begin
            nd = db_m;
            if (k - D + 1 > last_rst) begin
                for (int i = 0; i < 6; i++) begin
                    mis = 1'b1;
                    for (int j = 0; j < D; j++) begin
                        if (used_at(k - j)[i] == db_m[i]) mis = 1'b0;
                    end
                    if (mis) nd[i] = ~db_m[i];
                end
            end
            pr    = nd[5:2] & ~db_m[5:2];
            tog_m = tog_m ^ pr[0];
`ifdef RGB_BTN_TOGGLE_EN
            nc = {nd[1:0], tog_m};
`else
            nc = {nd[1:0], nd[2]};
`endif
            if (nc != code_m) code_q.push_back('{cyc: k, press: 4'd0});
            if (pr != 4'd0)   press_q.push_back('{cyc: k, press: pr});
            db_m   = nd;
            code_m = nc;
        end
        lvl_q.push_back('{cyc: k, code: code_m, sw: db_m[1:0], btn: db_m[5:2]});
    endtask

    task automatic step(input logic [1:0] s, input logic [3:0] b, input logic r);
        sw  = s;
        btn = b;
        rst = r;
        @(posedge clk);
        cyc = cyc + 1;
        model_edge(cyc, r, {b, s});
        mon_en = 1'b1;
        @(negedge clk);
    endtask

    task automatic hold(input logic [1:0] s, input logic [3:0] b, input int n);
        for (int i = 0; i < n; i++) step(s, b, 1'b0);
    endtask

    // monitor: pops expected levels each cycle and expected pulse events when due
    initial begin
        lvl_t       l;
        logic       exp_cv;
        logic [3:0] exp_pr;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                n_tests++;
                if (lvl_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL level_queue cyc=%0d got no expectation", cyc);
                end else begin
                    l = lvl_q.pop_front();
                    if ({code, sw_db, btn_db} !== {l.code, l.sw, l.btn}) begin
                        n_fail++;
                        $display("FAIL levels cyc=%0d got code=%b sw_db=%b btn_db=%b exp code=%b sw_db=%b btn_db=%b",
                                 cyc, code, sw_db, btn_db, l.code, l.sw, l.btn);
                    end
                end
                exp_cv = 1'b0;
                if (code_q.size() > 0 && code_q[0].cyc == cyc) begin
                    exp_cv = 1'b1;
                    void'(code_q.pop_front());
                end
                n_tests++;
                if (code_valid !== exp_cv) begin
                    n_fail++;
                    $display("FAIL code_valid cyc=%0d got %b exp %b", cyc, code_valid, exp_cv);
                end
                exp_pr = 4'd0;
                if (press_q.size() > 0 && press_q[0].cyc == cyc) begin
                    exp_pr = press_q[0].press;
                    void'(press_q.pop_front());
                end
                n_tests++;
                if (btn_press !== exp_pr) begin
                    n_fail++;
                    $display("FAIL btn_press cyc=%0d got %b exp %b", cyc, btn_press, exp_pr);
                end
            end
        end
    end

    // stimulus: directed scenarios then randomized segments with occasional resets
    initial begin
        logic [1:0] rs;
        logic [3:0] rb;
        logic [5:0] raw;
        int         len;

        // reset held with all inputs asserted, then release
        for (int i = 0; i < 3; i++) step(2'b11, 4'hF, 1'b1);
        hold(2'b11, 4'hF, 12);

        // clean switch change
        hold(2'b00, 4'h0, 12);
        hold(2'b10, 4'h0, 12);

        // bouncing btn[0]
        hold(2'b00, 4'h0, 12);
        step(2'b00, 4'h1, 1'b0);
        step(2'b00, 4'h0, 1'b0);
        step(2'b00, 4'h1, 1'b0);
        step(2'b00, 4'h0, 1'b0);
        hold(2'b00, 4'h1, 12);

        // simultaneous rise, then staggered by two cycles
        hold(2'b00, 4'h0, 12);
        hold(2'b01, 4'h1, 12);
        hold(2'b00, 4'h0, 12);
        hold(2'b01, 4'h0, 2);
        hold(2'b01, 4'h1, 12);

        // reset in the middle of a btn[2] debounce
        hold(2'b00, 4'h0, 12);
        hold(2'b00, 4'h4, 3);
        step(2'b00, 4'h4, 1'b1);
        hold(2'b00, 4'h4, 12);

        // two press/release cycles of btn[0]
        hold(2'b00, 4'h0, 12);
        hold(2'b00, 4'h1, 10);
        hold(2'b00, 4'h0, 10);
        hold(2'b00, 4'h1, 10);
        hold(2'b00, 4'h0, 12);

        // randomized segments: short holds bounce, long holds commit
        raw = 6'd0;
        for (int seg = 0; seg < 320; seg++) begin
            if ($urandom_range(0, 3) == 0) raw = raw ^ 6'($urandom);
            else raw = raw ^ (6'd1 << $urandom_range(0, 5));
            rs  = raw[1:0];
            rb  = raw[5:2];
            len = $urandom_range(1, 9);
            if ($urandom_range(0, 59) == 0) step(rs, rb, 1'b1);
            hold(rs, rb, len);
        end
        hold(2'b00, 4'h0, 12);

        n_tests++;
        if (code_q.size() != 0 || press_q.size() != 0) begin
            n_fail++;
            $display("FAIL pending_events got code=%0d press=%0d exp 0 0", code_q.size(), press_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
